// File: rtl/parity_frame_receiver.sv
// Serial-to-parallel receiver for parity-protected word frames: WIDTH data bits
// LSB-first followed by one parity bit, with a one-deep output slot and error count.
module parity_frame_receiver #(
  parameter int WIDTH      = 32,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic                 rx_bit,
  output logic                 rx_ready,
  input  logic                 rx_sync,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_par_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam int                   CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]     PAR_POS = CNT_W'(WIDTH);
  localparam logic                 ODD     = (ODD_PARITY != 0);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next, base_cnt;
  logic [WIDTH-1:0]     shift_reg, shift_next, base_shift;
  logic                 par_reg, par_next, base_par;
  logic                 out_valid_reg;
  logic [WIDTH-1:0]     out_data_reg;
  logic                 out_par_err_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic parity_phase, accept, frame_done, data_accept, frame_err;

  // Only the parity bit can stall, and only when the output slot cannot be freed.
  assign parity_phase = (bit_cnt_reg == PAR_POS);
  assign rx_ready     = rx_sync || !(parity_phase && out_valid_reg && !out_ready);
  assign accept       = rx_valid && rx_ready;
  assign frame_done   = accept && !rx_sync && parity_phase;
  assign data_accept  = accept && !frame_done;
  assign frame_err    = par_reg ^ rx_bit ^ ODD;

  // rx_sync restarts the frame; a bit presented with it lands as data bit 0.
  assign base_cnt   = rx_sync ? '0 : bit_cnt_reg;
  assign base_shift = rx_sync ? '0 : shift_reg;
  assign base_par   = rx_sync ? 1'b0 : par_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      assign shift_next[gi] = frame_done ? 1'b0 :
                              (data_accept && (base_cnt == CNT_W'(gi))) ? rx_bit :
                              base_shift[gi];
    end
  endgenerate

  assign bit_cnt_next = frame_done  ? '0 :
                        data_accept ? base_cnt + CNT_W'(1) :
                        base_cnt;
  assign par_next     = frame_done ? 1'b0 : (base_par ^ (data_accept & rx_bit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      par_reg         <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_par_err_reg <= 1'b0;
      err_cnt_reg     <= '0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      // A completing frame reloads the slot even while it is being drained.
      if (frame_done) begin
        out_valid_reg   <= 1'b1;
        out_data_reg    <= shift_reg;
        out_par_err_reg <= frame_err;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (frame_done && frame_err && (err_cnt_reg != ERR_MAX)) begin
        err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_par_err = out_par_err_reg;
  assign err_cnt     = err_cnt_reg;
  assign busy        = (bit_cnt_reg != '0);

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed bench: three 8-bit receivers (even, odd, 2-bit error counter) share
// one stimulus bus; expected values are hand-computed per frame.
module tb_parity_frame_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rx_valid, rx_bit, rx_sync, out_ready;

  logic       ev_rx_ready, ev_out_valid, ev_out_par_err, ev_busy;
  logic [7:0] ev_out_data, ev_err_cnt;
  logic       od_rx_ready, od_out_valid, od_out_par_err, od_busy;
  logic [7:0] od_out_data, od_err_cnt;
  logic       st_rx_ready, st_out_valid, st_out_par_err, st_busy;
  logic [7:0] st_out_data;
  logic [1:0] st_err_cnt;

  parity_frame_receiver #(.WIDTH(8), .ODD_PARITY(0), .ERR_CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_ready(ev_rx_ready),
    .rx_sync(rx_sync), .out_valid(ev_out_valid), .out_ready(out_ready), .out_data(ev_out_data),
    .out_par_err(ev_out_par_err), .err_cnt(ev_err_cnt), .busy(ev_busy));

  parity_frame_receiver #(.WIDTH(8), .ODD_PARITY(1), .ERR_CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_ready(od_rx_ready),
    .rx_sync(rx_sync), .out_valid(od_out_valid), .out_ready(out_ready), .out_data(od_out_data),
    .out_par_err(od_out_par_err), .err_cnt(od_err_cnt), .busy(od_busy));

  parity_frame_receiver #(.WIDTH(8), .ODD_PARITY(0), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_ready(st_rx_ready),
    .rx_sync(rx_sync), .out_valid(st_out_valid), .out_ready(out_ready), .out_data(st_out_data),
    .out_par_err(st_out_par_err), .err_cnt(st_err_cnt), .busy(st_busy));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents one bit and returns at posedge+1 of the edge that accepted it.
  task automatic send_bit(input logic b, input logic s);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_bit   = b;
    rx_sync  = s;
    @(negedge clk);
    while (!ev_rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rx_ready_wait", 32'(ev_rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_sync  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic sync_first);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == 0) && sync_first);
    send_bit(p, 1'b0);
    last_done = cyc;
    $display("frame sent=%02h par=%b -> out_data=%02h par_err=%b err_cnt=%0d",
             d, p, ev_out_data, ev_out_par_err, ev_err_cnt);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev;
    logic [7:0] b2b [4];
    logic [7:0] tmp;
    b2b[0] = 8'h01; b2b[1] = 8'h80; b2b[2] = 8'hFF; b2b[3] = 8'h00;

    rst_n = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0; rx_sync = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(ev_out_valid), 32'd0);
    check("rst_out_data", 32'(ev_out_data), 32'd0);
    check("rst_par_err", 32'(ev_out_par_err), 32'd0);
    check("rst_err_cnt", 32'(ev_err_cnt), 32'd0);
    check("rst_busy", 32'(ev_busy), 32'd0);
    check("rst_rx_ready", 32'(ev_rx_ready), 32'd1);
    rst_n = 1'b1;
    idle_cycle();

    // Good even-parity frame
    send_frame(8'hA5, 1'b0, 1'b0);
    check("t1_valid", 32'(ev_out_valid), 32'd1);
    check("t1_data", 32'(ev_out_data), 32'hA5);
    check("t1_par_err", 32'(ev_out_par_err), 32'd0);
    check("t1_err_cnt", 32'(ev_err_cnt), 32'd0);
    check("t1_odd_par_err", 32'(od_out_par_err), 32'd1);
    idle_cycle();
    check("t1_drop", 32'(ev_out_valid), 32'd0);

    // Bad even parity, good odd parity
    send_frame(8'hA5, 1'b1, 1'b0);
    check("t2_par_err", 32'(ev_out_par_err), 32'd1);
    check("t2_err_cnt", 32'(ev_err_cnt), 32'd1);
    check("t2_odd_par_err", 32'(od_out_par_err), 32'd0);
    check("t2_odd_err_cnt", 32'(od_err_cnt), 32'd1);
    idle_cycle();

    // Back-pressure: second parity bit stalls until the slot drains
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    check("bp_valid1", 32'(ev_out_valid), 32'd1);
    check("bp_data1", 32'(ev_out_data), 32'h3C);
    tmp = 8'h0F;
    for (int i = 0; i < 8; i++) send_bit(tmp[i], 1'b0);
    rx_valid = 1'b1; rx_bit = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("bp_stall_ready", 32'(ev_rx_ready), 32'd0);
      check("bp_hold_data", 32'(ev_out_data), 32'h3C);
      check("bp_busy", 32'(ev_busy), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(ev_rx_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0; rx_valid = 1'b0;
    $display("frame sent=0f par=0 -> out_data=%02h par_err=%b err_cnt=%0d",
             ev_out_data, ev_out_par_err, ev_err_cnt);
    check("bp_valid2", 32'(ev_out_valid), 32'd1);
    check("bp_data2", 32'(ev_out_data), 32'h0F);
    check("bp_busy_after", 32'(ev_busy), 32'd0);
    idle_cycle();
    check("bp_stable", 32'(ev_out_data), 32'h0F);
    check("bp_stable_valid", 32'(ev_out_valid), 32'd1);
    out_ready = 1'b1;
    idle_cycle();
    check("bp_drained", 32'(ev_out_valid), 32'd0);
    check("bp_odd_err_cnt", 32'(od_err_cnt), 32'd3);

    // Back-to-back frames, even parity, no gaps
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      send_frame(b2b[k], ^b2b[k], 1'b0);
      check("b2b_valid", 32'(ev_out_valid), 32'd1);
      check("b2b_data", 32'(ev_out_data), 32'(b2b[k]));
      if (k > 0) check("b2b_spacing", 32'(last_done - prev), 32'd9);
      prev = last_done;
    end
    check("b2b_err_cnt", 32'(ev_err_cnt), 32'd1);
    check("b2b_odd_err_cnt", 32'(od_err_cnt), 32'd7);
    idle_cycle();

    // Re-align after a 5-bit partial frame
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    check("sync_busy_before", 32'(ev_busy), 32'd1);
    send_frame(8'h5A, 1'b0, 1'b1);
    check("sync_data", 32'(ev_out_data), 32'h5A);
    check("sync_par_err", 32'(ev_out_par_err), 32'd0);
    check("sync_err_cnt", 32'(ev_err_cnt), 32'd1);
    idle_cycle();

    // rx_sync in the parity phase aborts the frame
    tmp = 8'h33;
    for (int i = 0; i < 8; i++) send_bit(tmp[i], 1'b0);
    rx_sync = 1'b1;
    idle_cycle();
    rx_sync = 1'b0;
    check("abort_busy", 32'(ev_busy), 32'd0);
    check("abort_valid", 32'(ev_out_valid), 32'd0);
    check("abort_err_cnt", 32'(ev_err_cnt), 32'd1);

    // Reset mid-frame with the output slot full
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    check("mrst_busy_before", 32'(ev_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(ev_busy), 32'd0);
    check("mrst_valid", 32'(ev_out_valid), 32'd0);
    check("mrst_data", 32'(ev_out_data), 32'd0);
    check("mrst_err_cnt", 32'(ev_err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle_cycle();

    // Counter saturation
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'hA5, 1'b1, 1'b0);
      check("sat_err_cnt", 32'(st_err_cnt), (k < 3) ? 32'(k) : 32'd3);
      check("sat_wide_err_cnt", 32'(ev_err_cnt), 32'(k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
